// File: rtl/enemy_wave_ctrl.sv
// enemy_wave_ctrl: wave/difficulty scheduler giving spawn permission, move tick and level.
module enemy_wave_ctrl #(
  parameter int N_LEVEL            = 4,
  parameter int KILLS_PER_WAVE     = 16,
  parameter int CW                 = 24,
  parameter int BASE_COOLDOWN      = 9_999_999,
  parameter int COOLDOWN_STEP      = 1_000_000,
  parameter int MIN_COOLDOWN       = 2_000_000,
  parameter int BASE_MOVE_PERIOD   = 1_000_000,
  parameter int MOVE_STEP          = 100_000,
  parameter int MIN_MOVE_PERIOD    = 400_000,
  parameter int INTERMISSION_TICKS = 50_000_000,
  localparam int LW = N_LEVEL > 1 ? $clog2(N_LEVEL) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          gameover,
  input  logic          killed,
  input  logic          spawned,
  output logic          spawn_allow,
  output logic          move,
  output logic [LW-1:0] level,
  output logic          wave_done,
  output logic          intermission
);
  localparam int KW = $clog2(KILLS_PER_WAVE + 1);
  localparam int BW = INTERMISSION_TICKS > 1 ? $clog2(INTERMISSION_TICKS) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAVE, S_BREAK} state_t;
  state_t state;
  logic [KW-1:0] kill_cnt, spawns_left;
  logic [CW-1:0] cd_cnt, mv_cnt, cd_dec, mv_dec, cur_cd, cur_mv;
  logic [BW-1:0] br_cnt;
  logic wave_end;
  // Level-scaled periods clamp to their floor instead of underflowing.
  always_comb begin
    cd_dec = CW'(level) * CW'(COOLDOWN_STEP);
    mv_dec = CW'(level) * CW'(MOVE_STEP);
    cur_cd = cd_dec >= CW'(BASE_COOLDOWN - MIN_COOLDOWN) ? CW'(MIN_COOLDOWN) : CW'(BASE_COOLDOWN) - cd_dec;
    cur_mv = mv_dec >= CW'(BASE_MOVE_PERIOD - MIN_MOVE_PERIOD) ? CW'(MIN_MOVE_PERIOD) : CW'(BASE_MOVE_PERIOD) - mv_dec;
  end
  assign spawn_allow  = state == S_WAVE && cd_cnt == cur_cd && spawns_left != '0;
  assign move         = state == S_WAVE && mv_cnt == cur_mv - CW'(1);
  assign intermission = state == S_BREAK;
  assign wave_end     = killed && kill_cnt == KW'(KILLS_PER_WAVE - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      level       <= '0;
      kill_cnt    <= '0;
      spawns_left <= '0;
      cd_cnt      <= '0;
      mv_cnt      <= '0;
      br_cnt      <= '0;
      wave_done   <= 1'b0;
    end else begin
      wave_done <= 1'b0;
      case (state)
        S_IDLE: begin
          level       <= '0;
          kill_cnt    <= '0;
          spawns_left <= KW'(KILLS_PER_WAVE);
          cd_cnt      <= '0;
          mv_cnt      <= '0;
          if (start) state <= S_WAVE;
        end
        S_WAVE: begin
          if (gameover) state <= S_IDLE;
          else begin
            cd_cnt      <= spawned ? '0 : cd_cnt < cur_cd ? cd_cnt + 1'b1 : cd_cnt;
            spawns_left <= spawned && spawns_left != '0 ? spawns_left - 1'b1 : spawns_left;
            mv_cnt      <= mv_cnt >= cur_mv - CW'(1) ? '0 : mv_cnt + 1'b1;
            if (killed) kill_cnt <= kill_cnt + 1'b1;
            if (wave_end) begin
              state     <= S_BREAK;
              wave_done <= 1'b1;
              br_cnt    <= '0;
              if (level != LW'(N_LEVEL - 1)) level <= level + 1'b1;
            end
          end
        end
        S_BREAK: begin
          if (gameover) state <= S_IDLE;
          else if (br_cnt == BW'(INTERMISSION_TICKS - 1)) begin
            state       <= S_WAVE;
            kill_cnt    <= '0;
            spawns_left <= KW'(KILLS_PER_WAVE);
            cd_cnt      <= '0;
            mv_cnt      <= '0;
          end else br_cnt <= br_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/enemy_wave_ctrl.md
Name: enemy_wave_ctrl

Overview:
- Wave/difficulty scheduler for the enemy pool.
- Decides when the pool may spawn the next enemy (spawn permission plus cooldown) and generates the enemy move tick.
- Counts kills per wave, inserts an intermission between waves, and raises the difficulty level each wave.
- Sits beside the enemy pool; replaces a fixed respawn counter and a fixed move controller with level-scaled timing.

Parameters:
- N_LEVEL, 4, number of difficulty levels; level saturates at N_LEVEL-1
- KILLS_PER_WAVE, 16, kills that complete a wave; also the spawn budget per wave
- CW, 24, width of all tick counters and period values
- BASE_COOLDOWN, 9_999_999, respawn cooldown ticks at level 0
- COOLDOWN_STEP, 1_000_000, cooldown reduction per level
- MIN_COOLDOWN, 2_000_000, cooldown floor
- BASE_MOVE_PERIOD, 1_000_000, clocks between move pulses at level 0
- MOVE_STEP, 100_000, move period reduction per level
- MIN_MOVE_PERIOD, 400_000, move period floor (must be ≥2)
- INTERMISSION_TICKS, 50_000_000, intermission length in clocks

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; forces idle
- start  in  1  level; begin game from idle
- gameover  in  1  level; abort to idle
- killed  in  1  1-cycle pulse, an enemy was shot
- spawned  in  1  1-cycle pulse, pool consumed a spawn permission
- spawn_allow  out  1  pool may spawn this cycle
- move  out  1  1-cycle enemy step pulse
- level  out  $clog2(N_LEVEL)  current difficulty level
- wave_done  out  1  1-cycle pulse on wave completion
- intermission  out  1  high while in S_BREAK

Behaviour:
Reset:
- Async reset gives state S_IDLE and clears level, kill_cnt, spawns_left, cd_cnt, mv_cnt and br_cnt.
- All outputs are 0 during and after reset.

Derived periods (combinational, width CW, no underflow):
- cur_cd = (level*COOLDOWN_STEP ≥ BASE_COOLDOWN-MIN_COOLDOWN) ? MIN_COOLDOWN : BASE_COOLDOWN - level*COOLDOWN_STEP.
- cur_mv is computed the same way from the move parameters.

FSM states: S_IDLE, S_WAVE, S_BREAK.

S_IDLE:
- On start, go to S_WAVE next cycle.
- level=0, kill_cnt=0, spawns_left=KILLS_PER_WAVE, cd_cnt=0, mv_cnt=0.

S_WAVE:
- cd_cnt increments each clock while below cur_cd, then holds.
- spawn_allow = (cd_cnt==cur_cd) & (spawns_left!=0), combinational.
- spawned in S_WAVE sets cd_cnt=0 and spawns_left-- (saturates at 0). This applies even if spawn_allow was low.
- First spawn_allow rises cur_cd clocks after entering S_WAVE.
- mv_cnt counts 0..cur_mv-1 and wraps. move=1 in the cycle mv_cnt==cur_mv-1, giving one pulse every cur_mv clocks.
- killed increments kill_cnt.
- killed while kill_cnt==KILLS_PER_WAVE-1 triggers all of: go to S_BREAK next cycle, wave_done=1 for one cycle (registered, the cycle after the kill), level++ saturating at N_LEVEL-1, br_cnt=0.

S_BREAK:
- intermission=1; spawn_allow=0; move=0.
- killed and spawned are ignored.
- br_cnt increments. When br_cnt==INTERMISSION_TICKS-1, go to S_WAVE with kill_cnt=0, spawns_left=KILLS_PER_WAVE, cd_cnt=0, mv_cnt=0.

Priorities and simultaneous events:
- gameover in S_WAVE or S_BREAK goes to S_IDLE next cycle. It beats killed, spawned and wave completion; level is not incremented on that cycle.
- start outside S_IDLE is ignored.
- start and gameover both high in S_IDLE: start wins.
- killed and spawned in the same cycle are both applied.
- Level changes take effect on cur_cd and cur_mv from the next S_WAVE onward. They are stable during S_BREAK.
- A level change does not reset in-flight counters beyond the reloads listed above.

Test Plan:
Bench parameters: N_LEVEL=4, KILLS_PER_WAVE=3, CW=8, BASE_COOLDOWN=10, COOLDOWN_STEP=4, MIN_COOLDOWN=3, BASE_MOVE_PERIOD=5, MOVE_STEP=1, MIN_MOVE_PERIOD=2, INTERMISSION_TICKS=6.
1. Reset then start pulse → S_WAVE; spawn_allow rises exactly 10 clocks later; move pulses every 5 clocks; level=0.
2. spawned pulse while spawn_allow high → spawn_allow drops next cycle and rises again 10 clocks later. After 3 spawns, spawn_allow stays 0 indefinitely.
3. Three killed pulses → wave_done one cycle after the third; intermission=1 for 6 clocks with move=0; level=1; next wave cooldown 6 and move period 4.
4. Complete 3 waves → level 3, saturating thereafter; cooldown clamps to 3 (10-12 underflow avoided); move period 2. A 4th wave leaves level at 3.
5. gameover asserted in the same cycle as the wave-completing killed → S_IDLE, no wave_done, level unchanged. A killed pulse during S_BREAK leaves kill_cnt unchanged.
6. Async reset mid-S_BREAK, asserted off a clock edge → all outputs 0 immediately, state S_IDLE; a subsequent start restarts at level 0.
